// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and helpers for the UART RX frame controller.
// Holds the FSM state encoding, default widths and the sample-edge helper.
package uart_rx_pkg;

  localparam int DATA_W_DFLT     = 8;
  localparam int PRESCALE_W_DFLT = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Edge on which the sampler delivers its voted third sample.
  function automatic int unsigned half_plus2(input int unsigned p);
    return (p >> 1) + 2;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: per-bit edge counter (wraps at P-1) and bit counter.
// Ports: clock/reset, clr_i, en_i, bit_clr_i, bit_inc_i, prescale_i -> edge_cnt_o, bit_cnt_o, wrap_o.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DFLT,
  parameter int BIT_W      = 3
) (
  input  logic                  Sampler_CLK,
  input  logic                  Sampler_RST,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  bit_clr_i,
  input  logic                  bit_inc_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]      bit_cnt_o,
  output logic                  wrap_o
);

  logic [PRESCALE_W-1:0] edge_q;
  logic [BIT_W-1:0]      bit_q;

  assign wrap_o = en_i &&
    (edge_q == prescale_i - PRESCALE_W'(1));
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

  always_ff @(posedge Sampler_CLK or negedge Sampler_RST) begin
    if (!Sampler_RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (clr_i) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (en_i) begin
      if (wrap_o) begin
        edge_q <= '0;
        if (bit_clr_i) begin
          bit_q <= '0;
        end else if (bit_inc_i) begin
          bit_q <= bit_q + BIT_W'(1);
        end
      end else begin
        edge_q <= edge_q + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART RX frame FSM, LSB-first deserializer, parity/stop check.
// Ports: Sampler_CLK/RST, RX_IN, Prescale, Par_En/Typ, Sample_Bit/Valid in; Edge_Cnt,
// Data_Samp_En, P_Data, Data_Valid, Par_Err, Stp_Err out; Break_Det if UART_RX_BREAK_DET_EN.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int PRESCALE_W = PRESCALE_W_DFLT
) (
  input  logic                  Sampler_CLK,
  input  logic                  Sampler_RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic                  Sample_Bit,
  input  logic                  Sample_Valid,
  output logic [PRESCALE_W-1:0] Edge_Cnt,
  output logic                  Data_Samp_En,
  output logic [DATA_W-1:0]     P_Data,
  output logic                  Data_Valid,
  output logic                  Par_Err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  Stp_Err,
  output logic                  Break_Det
`else
  output logic                  Stp_Err
`endif
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_e             state_q;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] p_new;
  logic [PRESCALE_W-1:0] p_cnt;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_W-1:0]     shift_q;
  logic [DATA_W-1:0]     p_data_q;
  logic par_en_q;
  logic par_typ_q;
  logic err_p_q;
  logic samp_en_q;
  logic dv_q;
  logic pe_q;
  logic se_q;
  logic wrap;
  logic start_det;
  logic samp_hit;
  logic glitch;
  logic stop_hit;
  logic cnt_clr;
  logic cnt_en;
`ifdef UART_RX_BREAK_DET_EN
  logic par_bit_q;
  logic brk_q;
`endif

  always_comb begin
    p_new     = Prescale & ~PRESCALE_W'(1);
    // The detect cycle counts with the fresh prescale; later cycles use the latched one.
    p_cnt     = (state_q == IDLE) ? p_new : p_q;
    start_det = (state_q == IDLE) && !RX_IN;
    samp_hit  = Sample_Valid && (state_q != IDLE) &&
      (edge_cnt == PRESCALE_W'(half_plus2(32'(p_q))));
    glitch    = samp_hit && (state_q == START) && Sample_Bit;
    stop_hit  = samp_hit && (state_q == STOP);
    cnt_clr   = glitch || stop_hit;
    cnt_en    = start_det || (state_q != IDLE);
  end

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .Sampler_CLK (Sampler_CLK),
    .Sampler_RST (Sampler_RST),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .bit_clr_i   (state_q == START),
    .bit_inc_i   (state_q == DATA),
    .prescale_i  (p_cnt),
    .edge_cnt_o  (edge_cnt),
    .bit_cnt_o   (bit_cnt),
    .wrap_o      (wrap)
  );

  always_ff @(posedge Sampler_CLK or negedge Sampler_RST) begin
    if (!Sampler_RST) begin
      state_q   <= IDLE;
      p_q       <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      shift_q   <= '0;
      p_data_q  <= '0;
      err_p_q   <= 1'b0;
      samp_en_q <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q <= 1'b0;
      brk_q     <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (start_det) begin
            p_q       <= p_new;
            par_en_q  <= Par_En;
            par_typ_q <= Par_Typ;
            shift_q   <= '0;
            err_p_q   <= 1'b0;
            samp_en_q <= 1'b1;
            state_q   <= START;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (glitch) begin
            samp_en_q <= 1'b0;
            state_q   <= IDLE;
          end else if (wrap) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (samp_hit) begin
            shift_q[bit_cnt] <= Sample_Bit;
          end
          if (wrap && (bit_cnt == BIT_W'(DATA_W - 1))) begin
            state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (samp_hit) begin
            err_p_q <= Sample_Bit != (^shift_q ^ par_typ_q);
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q <= Sample_Bit;
`endif
          end
          if (wrap) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          // Leave on the sample, not the wrap, to catch a back-to-back start.
          if (stop_hit) begin
            samp_en_q <= 1'b0;
            state_q   <= IDLE;
            se_q      <= ~Sample_Bit;
            pe_q      <= err_p_q;
            dv_q      <= Sample_Bit & ~err_p_q;
            if (Sample_Bit & ~err_p_q) begin
              p_data_q <= shift_q;
            end
`ifdef UART_RX_BREAK_DET_EN
            brk_q <= ~Sample_Bit & ~|shift_q &
              (~par_en_q | ~par_bit_q);
`endif
          end
        end
        default: begin
          samp_en_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign Edge_Cnt     = edge_cnt;
  assign Data_Samp_En = samp_en_q;
  assign P_Data       = p_data_q;
  assign Data_Valid   = dv_q;
  assign Par_Err      = pe_q;
  assign Stp_Err      = se_q;
`ifdef UART_RX_BREAK_DET_EN
  assign Break_Det    = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: table-driven frames with a pulse scoreboard,
// plus glitch and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

  logic       Sampler_CLK = 1'b0;
  logic       Sampler_RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [4:0] Prescale = 5'd8;
  logic       Par_En = 1'b0;
  logic       Par_Typ = 1'b0;
  logic       Sample_Bit = 1'b1;
  logic       Sample_Valid = 1'b0;
  logic [4:0] Edge_Cnt;
  logic       Data_Samp_En;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;
`ifdef UART_RX_BREAK_DET_EN
  logic       Break_Det;
`endif

  uart_rx_frame_ctrl dut (
    .Sampler_CLK  (Sampler_CLK),
    .Sampler_RST  (Sampler_RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .Par_En       (Par_En),
    .Par_Typ      (Par_Typ),
    .Sample_Bit   (Sample_Bit),
    .Sample_Valid (Sample_Valid),
    .Edge_Cnt     (Edge_Cnt),
    .Data_Samp_En (Data_Samp_En),
    .P_Data       (P_Data),
    .Data_Valid   (Data_Valid),
    .Par_Err      (Par_Err),
`ifdef UART_RX_BREAK_DET_EN
    .Stp_Err      (Stp_Err),
    .Break_Det    (Break_Det)
`else
    .Stp_Err      (Stp_Err)
`endif
  );

  always #5 Sampler_CLK = ~Sampler_CLK;

  typedef struct {
    int         p_in;
    logic       pen;
    logic       ptyp;
    logic [7:0] d;
    logic       pbit;
    logic       stp;
    int         slen;
    int         gap;
    logic       edv;
    logic       epe;
    logic       ese;
    logic       ebrk;
  } vec_t;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic       brk;
    logic [7:0] pd;
  } sb_t;

  sb_t        sb[$];
  sb_t        mon_e;
  vec_t       tbl[14];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cur_p = 8;
  logic [7:0] last_good = 8'h00;
  logic       pulse;

  always @(posedge Sampler_CLK) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d",
        nm, act, exp, cyc);
    end
  endtask

  // Sampler model: true sample at P/2+2, plus decoy strobes the DUT must ignore.
  always @(posedge Sampler_CLK) begin
    #2;
    if (Data_Samp_En && Edge_Cnt == 5'(cur_p / 2 + 2)) begin
      Sample_Valid = 1'b1;
      Sample_Bit   = RX_IN;
    end else if (Data_Samp_En && Edge_Cnt == 5'd2) begin
      Sample_Valid = 1'b1;
      Sample_Bit   = ~RX_IN;
    end else if (!Data_Samp_En) begin
      Sample_Valid = cyc[0];
      Sample_Bit   = ~RX_IN;
    end else begin
      Sample_Valid = 1'b0;
      Sample_Bit   = ~RX_IN;
    end
  end

  always @(negedge Sampler_CLK) begin
    if (Sampler_RST) begin
      pulse = Data_Valid | Par_Err | Stp_Err;
`ifdef UART_RX_BREAK_DET_EN
      pulse = pulse | Break_Det;
`endif
      if (pulse) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse dv=%0b pe=%0b se=%0b required none cycle=%0d",
            Data_Valid, Par_Err, Stp_Err, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_cycle", cyc, mon_e.cyc);
          chk("data_valid", int'(Data_Valid), int'(mon_e.dv));
          chk("par_err", int'(Par_Err), int'(mon_e.pe));
          chk("stp_err", int'(Stp_Err), int'(mon_e.se));
          chk("p_data", int'(P_Data), int'(mon_e.pd));
`ifdef UART_RX_BREAK_DET_EN
          chk("break_det", int'(Break_Det), int'(mon_e.brk));
`endif
        end
      end
    end
  end

  task automatic line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Sampler_CLK);
      #1;
      RX_IN = v;
    end
  endtask

  task automatic send_frame(input vec_t v);
    int  p;
    int  len;
    sb_t e;
    p     = v.p_in & ~1;
    cur_p = p;
    @(posedge Sampler_CLK);
    #1;
    Prescale = 5'(v.p_in);
    Par_En   = v.pen;
    Par_Typ  = v.ptyp;
    RX_IN    = 1'b0;
    e.cyc = cyc + p * (9 + int'(v.pen)) + p / 2 + 3;
    e.dv  = v.edv;
    e.pe  = v.epe;
    e.se  = v.ese;
    e.brk = v.ebrk;
    if (v.edv) last_good = v.d;
    e.pd  = last_good;
    sb.push_back(e);
    @(posedge Sampler_CLK);
    #1;
    chk("edge_after_start", int'(Edge_Cnt), 1);
    chk("samp_en_start", int'(Data_Samp_En), 1);
    Prescale = 5'($urandom);
    Par_En   = 1'($urandom);
    Par_Typ  = 1'($urandom);
    line(1'b0, p - 2);
    for (int i = 0; i < 8; i++) line(v.d[i], p);
    if (v.pen) line(v.pbit, p);
    len = (v.slen == 0) ? p : v.slen;
    if (!v.stp) len = p / 2 + 3;
    line(v.stp, len);
    line(1'b1, v.gap);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(posedge Sampler_CLK);
    #1;
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    vec_t v;
    tbl[0]  = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 0,  4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0,  4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 0,  4, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0,  4, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{6,  1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 0,  4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{30, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 0,  4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{9,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 0,  4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8,  1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0,  4, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{12, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 0,  4, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{14, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b1, 0,  4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8,  1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 8,  0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8,  1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 0,  4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 12, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 0,  4, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge Sampler_CLK);
    #1;
    chk("rst_edge_cnt", int'(Edge_Cnt), 0);
    chk("rst_samp_en", int'(Data_Samp_En), 0);
    chk("rst_p_data", int'(P_Data), 0);
    chk("rst_dv", int'(Data_Valid), 0);
    chk("rst_pe", int'(Par_Err), 0);
    chk("rst_se", int'(Stp_Err), 0);
    #2;
    Sampler_RST = 1'b1;
    line(1'b1, 4);

    for (int i = 0; i < 14; i++) send_frame(tbl[i]);
    drain("drain_table");

    cur_p = 8;
    @(posedge Sampler_CLK);
    #1;
    Prescale = 5'd8;
    Par_En   = 1'b0;
    RX_IN    = 1'b0;
    t0       = cyc;
    chk("glitch_detect_edge", int'(Edge_Cnt), 0);
    @(posedge Sampler_CLK);
    #1;
    chk("glitch_edge1", int'(Edge_Cnt), 1);
    @(posedge Sampler_CLK);
    #1;
    RX_IN = 1'b1;
    while (cyc < t0 + 6) begin
      @(posedge Sampler_CLK);
      #1;
    end
    chk("glitch_samp_en_t6", int'(Data_Samp_En), 1);
    @(posedge Sampler_CLK);
    #1;
    chk("glitch_samp_en_t7", int'(Data_Samp_En), 0);
    chk("glitch_edge_t7", int'(Edge_Cnt), 0);
    line(1'b1, 6);
    chk("glitch_idle_edge", int'(Edge_Cnt), 0);
    chk("glitch_p_data", int'(P_Data), int'(last_good));

    v = '{8, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    cur_p = 8;
    @(posedge Sampler_CLK);
    #1;
    Prescale = 5'd8;
    Par_En   = 1'b0;
    RX_IN    = 1'b0;
    line(1'b0, 7);
    for (int i = 0; i < 4; i++) line(v.d[i], 8);
    line(v.d[4], 3);
    #2;
    Sampler_RST = 1'b0;
    #1;
    chk("midrst_samp_en", int'(Data_Samp_En), 0);
    chk("midrst_edge_cnt", int'(Edge_Cnt), 0);
    chk("midrst_p_data", int'(P_Data), 0);
    chk("midrst_dv", int'(Data_Valid), 0);
    chk("midrst_pe", int'(Par_Err), 0);
    chk("midrst_se", int'(Stp_Err), 0);
    last_good = 8'h00;
    repeat (3) @(posedge Sampler_CLK);
    #1;
    RX_IN = 1'b1;
    #2;
    Sampler_RST = 1'b1;
    line(1'b1, 3);
    v = '{8, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    send_frame(v);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
